// File: rtl/pc_out_arbiter_pkg.sv
// Shared types and constants for the PC output arbiter: FSM states, default
// word geometry and the fixed source indices of the PC-bound path.
package pc_out_arbiter_pkg;

  localparam int NPCcode  = 8;
  localparam int NPCdata  = 32;
  localparam int NPCroute = 2;

  localparam int NWORD_DEF = NPCcode + NPCdata + NPCroute;
  localparam int NSRC_DEF  = 3;
  localparam int NW_DEF    = 4;

  localparam int SRC_BD     = 0;
  localparam int SRC_FPGA   = 1;
  localparam int SRC_GLOBAL = 2;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Width of an index into n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_out_arbiter_if.sv
// Word channel bundle between the serialized-word sources, the arbiter and
// the PC output packer. The arbiter uses the slave view.
interface pc_out_arbiter_if
  import pc_out_arbiter_pkg::*;
#(
  parameter int Nsrc  = NSRC_DEF,
  parameter int Nword = NWORD_DEF
) ();

  localparam int Sw = idx_w(Nsrc);

  logic [Nsrc*Nword-1:0] in_d;
  logic [Nsrc-1:0]       in_last;
  logic [Nsrc-1:0]       in_v;
  logic [Nsrc-1:0]       in_a;
  logic [Nword-1:0]      out_d;
  logic [Sw-1:0]         out_src;
  logic                  out_v;
  logic                  out_a;

  modport master (
    output in_d, in_last, in_v, out_a,
    input  in_a, out_d, out_src, out_v
  );

  modport slave (
    input  in_d, in_last, in_v, out_a,
    output in_a, out_d, out_src, out_v
  );

endinterface

// File: rtl/pc_out_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: returns the first requester found
// scanning upward from i_ptr with wrap-around.
module pc_out_arbiter_rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  int w_best;
  int w_dist;

  // Smallest rotated distance from the pointer wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_best  = N;
    w_dist  = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr)) : (i + N - int'(i_ptr));
      if (i_req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_found = 1'b1;
        o_idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/pc_out_arbiter.sv
// Weighted round-robin arbiter sharing the PC-bound word path between the
// serializers; messages stay atomic and the output word is registered.
module pc_out_arbiter
  import pc_out_arbiter_pkg::*;
#(
  parameter int Nsrc  = NSRC_DEF,
  parameter int Nword = NWORD_DEF,
  parameter int Nw    = NW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Nsrc*Nw-1:0] weights,
  input  logic             enable,
  output logic             busy,
  pc_out_arbiter_if.slave  bus
);

  localparam int Sw = idx_w(Nsrc);

  arb_state_t       r_state, w_state_nx;
  logic [Sw-1:0]    r_ptr, w_ptr_nx;
  logic [Sw-1:0]    r_grant, w_grant_nx;
  logic [Nw-1:0]    r_credit, w_credit_nx;
  logic             r_mid, w_mid_nx;

  logic             r_out_v;
  logic [Nword-1:0] r_out_d;
  logic [Sw-1:0]    r_out_src;

  logic [Nsrc-1:0]  w_elig;
  logic             w_found;
  logic [Sw-1:0]    w_pick;
  logic [Nw-1:0]    w_pick_wt;
  logic             w_gv;
  logic             w_glast;
  logic [Nword-1:0] w_gd;
  logic             w_room;
  logic             w_xfer;
  logic             w_release;
  logic [Nw-1:0]    w_cred_dec;
  logic [Sw-1:0]    w_grant_inc;

  function automatic logic [Nw-1:0] sat_dec(input logic [Nw-1:0] c);
    return (c == '0) ? '0 : (c - Nw'(1));
  endfunction

  pc_out_arbiter_rr_pick #(
    .N  (Nsrc),
    .IW (Sw)
  ) u_pick (
    .i_req   (w_elig),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_room      = !r_out_v || bus.out_a;
  assign w_xfer      = (r_state == LOCK) && w_gv && w_room;
  assign w_grant_inc = (r_grant == Sw'(Nsrc - 1)) ? '0 : (r_grant + Sw'(1));

  // Source-side muxing: eligibility, granted word and per-source acknowledge.
  always_comb begin
    w_elig    = '0;
    bus.in_a  = '0;
    w_gv      = 1'b0;
    w_glast   = 1'b0;
    w_gd      = '0;
    w_pick_wt = '0;
    for (int i = 0; i < Nsrc; i++) begin
      w_elig[i]   = bus.in_v[i] && (weights[i*Nw +: Nw] != '0);
      bus.in_a[i] = (r_state == LOCK) && (r_grant == Sw'(i)) && w_room;
      if (r_grant == Sw'(i)) begin
        w_gv    = bus.in_v[i];
        w_glast = bus.in_last[i];
        w_gd    = bus.in_d[i*Nword +: Nword];
      end
      if (w_pick == Sw'(i)) begin
        w_pick_wt = weights[i*Nw +: Nw];
      end
    end
  end

  // A turn ends at a message boundary: out of credit, disabled, or the
  // granted source has nothing further to send. A stalled output freezes all.
  always_comb begin
    w_state_nx  = r_state;
    w_ptr_nx    = r_ptr;
    w_grant_nx  = r_grant;
    w_credit_nx = r_credit;
    w_mid_nx    = r_mid;
    w_release   = 1'b0;
    w_cred_dec  = sat_dec(r_credit);
    case (r_state)
      IDLE: begin
        if (enable && w_found) begin
          w_state_nx  = LOCK;
          w_grant_nx  = w_pick;
          w_credit_nx = w_pick_wt;
          w_mid_nx    = 1'b0;
        end
      end
      LOCK: begin
        if (w_xfer) begin
          w_credit_nx = w_cred_dec;
          w_mid_nx    = !w_glast;
          w_release   = w_glast && ((w_cred_dec == '0) || !enable);
        end else if (w_room && !r_mid) begin
          w_release = !w_gv || !enable;
        end
      end
      default: w_state_nx = IDLE;
    endcase
    if (w_release) begin
      w_state_nx = IDLE;
      w_ptr_nx   = w_grant_inc;
      w_mid_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_grant  <= '0;
      r_credit <= '0;
      r_mid    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_ptr    <= w_ptr_nx;
      r_grant  <= w_grant_nx;
      r_credit <= w_credit_nx;
      r_mid    <= w_mid_nx;
    end
  end

  // Output register: loads whenever it is empty or being drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_v   <= 1'b0;
      r_out_d   <= '0;
      r_out_src <= '0;
    end else if (w_room) begin
      r_out_v <= w_xfer;
      if (w_xfer) begin
        r_out_d   <= w_gd;
        r_out_src <= r_grant;
      end
    end
  end

  assign bus.out_v   = r_out_v;
  assign bus.out_d   = r_out_d;
  assign bus.out_src = r_out_src;
  assign busy        = (r_state == LOCK);

endmodule

// File: tb/tb_pc_out_arbiter.sv
// Bench for pc_out_arbiter: directed scenarios plus randomized traffic,
// scored against a message-level weighted round-robin model.
module tb_pc_out_arbiter;
  import pc_out_arbiter_pkg::*;

  localparam int NS = 3;
  localparam int NWD = 42;
  localparam int NWT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic busy;
  logic [NS*NWT-1:0] weights = '0;

  pc_out_arbiter_if #(.Nsrc(NS), .Nword(NWD)) bus ();

  pc_out_arbiter #(.Nsrc(NS), .Nword(NWD), .Nw(NWT)) dut (
    .clk     (clk),
    .reset   (reset),
    .weights (weights),
    .enable  (enable),
    .busy    (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int wt[NS];
  int mlen[NS][$];
  logic [NWD-1:0] sw[NS][$];
  bit sl[NS][$];
  logic [NWD-1:0] exp_d[$];
  int exp_s[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NS; i++) begin
      mlen[i].delete();
      sw[i].delete();
      sl[i].delete();
    end
  endtask

  task automatic add_msg(input int s, input int len);
    logic [NWD-1:0] wd;
    mlen[s].push_back(len);
    for (int j = 0; j < len; j++) begin
      wd = {2'(s), 8'($urandom), 32'($urandom)};
      sw[s].push_back(wd);
      sl[s].push_back(j == len - 1);
    end
  endtask

  // Message-level model: each turn serves whole messages while the credit
  // (weight minus words sent, floored at 0) stays positive and messages remain.
  task automatic build_exp();
    int mi[NS];
    int wp[NS];
    int ptr;
    int s;
    int credit;
    int len;
    bit more;
    exp_d.delete();
    exp_s.delete();
    for (int i = 0; i < NS; i++) begin
      mi[i] = 0;
      wp[i] = 0;
    end
    ptr = 0;
    while (1) begin
      s = -1;
      for (int k = 0; k < NS; k++) begin
        int c;
        c = (ptr + k) % NS;
        if (s < 0 && mi[c] < mlen[c].size() && wt[c] != 0) s = c;
      end
      if (s < 0) break;
      credit = wt[s];
      more = 1'b1;
      while (more) begin
        len = mlen[s][mi[s]];
        mi[s]++;
        for (int j = 0; j < len; j++) begin
          exp_d.push_back(sw[s][wp[s]]);
          exp_s.push_back(s);
          wp[s]++;
        end
        credit = (credit > len) ? credit - len : 0;
        more = (credit > 0) && (mi[s] < mlen[s].size());
      end
      ptr = (s + 1) % NS;
    end
  endtask

  task automatic do_reset(input string name);
    bus.in_v = '0;
    bus.in_last = '0;
    bus.in_d = '0;
    bus.out_a = 1'b0;
    enable = 1'b1;
    weights = {4'(wt[2]), 4'(wt[1]), 4'(wt[0])};
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk($sformatf("%s_rst_out_v", name), bus.out_v, 0);
    chk($sformatf("%s_rst_busy", name), busy, 0);
    chk($sformatf("%s_rst_in_a", name), bus.in_a, 0);
    chk($sformatf("%s_rst_out_d", name), bus.out_d, 0);
    chk($sformatf("%s_rst_out_src", name), bus.out_src, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_scn(input string name, input int oa_pct, input int stall_lo,
                         input int stall_hi, input int drop_after, input bit rst_mid,
                         input int keep, input int exp_busy);
    int pos[NS];
    bit adv[NS];
    int taken;
    int n_exp;
    int out_cnt;
    int busy_cyc;
    int first_c;
    int last_c;
    int tail;
    bit stalled;
    bit fired;
    logic [NWD-1:0] held_d;
    logic [1:0] held_s;
    build_exp();
    if (keep >= 0) begin
      while (exp_d.size() > keep) begin
        void'(exp_d.pop_back());
        void'(exp_s.pop_back());
      end
    end
    n_exp = exp_d.size();
    for (int i = 0; i < NS; i++) begin
      pos[i] = 0;
      adv[i] = 1'b0;
    end
    taken = 0; out_cnt = 0; busy_cyc = 0; first_c = -1; last_c = -1;
    tail = 0; stalled = 1'b0; fired = 1'b0; held_d = '0; held_s = '0;
    do_reset(name);
    for (int cyc = 0; cyc < 3000 && tail < 12; cyc++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (adv[i]) pos[i]++;
        adv[i] = 1'b0;
      end
      if (drop_after >= 0 && taken >= drop_after) enable = 1'b0;
      for (int i = 0; i < NS; i++) begin
        if (pos[i] < sw[i].size()) begin
          bus.in_v[i] = 1'b1;
          bus.in_d[i*NWD +: NWD] = sw[i][pos[i]];
          bus.in_last[i] = sl[i][pos[i]];
        end else begin
          bus.in_v[i] = 1'b0;
          bus.in_last[i] = 1'b0;
        end
      end
      bus.out_a = (cyc >= stall_lo && cyc <= stall_hi) ? 1'b0
                  : ($urandom_range(99) < oa_pct);
      #1;
      if (rst_mid && bus.out_v && bus.out_src == 2'd1 && busy) begin
        reset = 1'b0;
        #1;
        chk($sformatf("%s_mid_out_v", name), bus.out_v, 0);
        chk($sformatf("%s_mid_busy", name), busy, 0);
        chk($sformatf("%s_mid_in_a", name), bus.in_a, 0);
        fired = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
      if (stalled) begin
        chk($sformatf("%s_hold_d", name), bus.out_d, held_d);
        chk($sformatf("%s_hold_src", name), bus.out_src, held_s);
      end
      stalled = bus.out_v && !bus.out_a;
      if (stalled) begin
        chk($sformatf("%s_stall_in_a", name), bus.in_a, 0);
        held_d = bus.out_d;
        held_s = bus.out_src;
      end
      for (int i = 0; i < NS; i++) begin
        if (bus.in_v[i] && bus.in_a[i]) begin
          adv[i] = 1'b1;
          taken++;
        end
      end
      if (bus.out_v && bus.out_a) begin
        out_cnt++;
        if (exp_d.size() == 0) begin
          chk($sformatf("%s_extra_out", name), out_cnt, n_exp);
        end else begin
          chk($sformatf("%s_src_%0d", name, out_cnt), bus.out_src, exp_s[0]);
          chk($sformatf("%s_data_%0d", name, out_cnt), bus.out_d, exp_d[0]);
          void'(exp_d.pop_front());
          void'(exp_s.pop_front());
          if (first_c < 0) first_c = cyc;
          last_c = cyc;
        end
      end
      if (exp_d.size() == 0) tail++;
    end
    if (rst_mid) begin
      chk($sformatf("%s_rst_fired", name), fired, 1);
    end else begin
      chk($sformatf("%s_pending", name), exp_d.size(), 0);
      chk($sformatf("%s_taken", name), taken, n_exp);
      if (exp_busy >= 0) begin
        chk($sformatf("%s_busy_cycles", name), busy_cyc, exp_busy);
        chk($sformatf("%s_span", name), last_c - first_c, n_exp - 1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_v = '0;
    bus.in_last = '0;
    bus.in_d = '0;
    bus.out_a = 1'b0;
    repeat (2) @(negedge clk);

    clear_srcs();
    wt = '{1, 1, 1};
    add_msg(SRC_BD, 3);
    run_scn("single", 100, -1, -2, -1, 1'b0, -1, 3);

    clear_srcs();
    wt = '{2, 1, 1};
    for (int k = 0; k < 6; k++) add_msg(SRC_BD, 1);
    for (int k = 0; k < 3; k++) add_msg(SRC_FPGA, 1);
    for (int k = 0; k < 3; k++) add_msg(SRC_GLOBAL, 1);
    run_scn("fair", 100, -1, -2, -1, 1'b0, -1, -1);

    clear_srcs();
    wt = '{1, 1, 1};
    add_msg(SRC_FPGA, 4);
    add_msg(SRC_GLOBAL, 1);
    run_scn("atomic", 100, -1, -2, -1, 1'b0, -1, -1);

    clear_srcs();
    wt = '{1, 1, 0};
    add_msg(SRC_BD, 2);
    add_msg(SRC_FPGA, 1);
    add_msg(SRC_GLOBAL, 2);
    add_msg(SRC_GLOBAL, 1);
    run_scn("wzero", 100, -1, -2, -1, 1'b0, -1, -1);

    clear_srcs();
    wt = '{4, 1, 1};
    add_msg(SRC_BD, 3);
    add_msg(SRC_BD, 3);
    run_scn("endrop", 100, -1, -2, 2, 1'b0, 3, -1);

    clear_srcs();
    wt = '{1, 1, 1};
    add_msg(SRC_BD, 8);
    add_msg(SRC_FPGA, 2);
    run_scn("bpress", 100, 4, 8, -1, 1'b0, -1, -1);

    clear_srcs();
    wt = '{1, 1, 1};
    add_msg(SRC_BD, 1);
    add_msg(SRC_FPGA, 4);
    run_scn("rstmid", 100, -1, -2, -1, 1'b1, -1, -1);

    clear_srcs();
    wt = '{1, 1, 1};
    add_msg(SRC_BD, 1);
    add_msg(SRC_FPGA, 1);
    add_msg(SRC_GLOBAL, 1);
    run_scn("postrst", 100, -1, -2, -1, 1'b0, -1, -1);

    for (int r = 0; r < 6; r++) begin
      clear_srcs();
      for (int i = 0; i < NS; i++) begin
        wt[i] = $urandom_range(3);
        for (int m = 0; m < int'($urandom_range(4)); m++) add_msg(i, 1 + $urandom_range(3));
      end
      run_scn($sformatf("rand%0d", r), 65, (r == 5) ? 6 : -1, (r == 5) ? 12 : -2,
              -1, 1'b0, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_out_arbiter.md
Name: pc_out_arbiter

Overview:
- Weighted round-robin arbiter that shares the single PC-bound word path between Nsrc serialized-word sources: BD serializer, FPGA serializer and global-tag parser.
- Sits between those sources and the PC output packer/FIFO.
- Keeps multi-word messages atomic, enforces per-source word budgets taken from config registers, and registers its output.

Parameters:
- Nsrc, 3, number of requesting sources.
- Nword, 42, width of one output word (code + data + route).
- Nw, 4, width of each per-source weight (words per turn).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- in_d  in  Nsrc*Nword  source words; source i occupies bits [i*Nword +: Nword].
- in_last  in  Nsrc  word is the final word of its message.
- in_v  in  Nsrc  source valid.
- in_a  out  Nsrc  source acknowledge.
- weights  in  Nsrc*Nw  per-source budget in words per turn; 0 disables the source.
- enable  in  1  arbitration enable from config.
- out_d  out  Nword  granted word.
- out_src  out  clog2(Nsrc)  index of the source that produced out_d.
- out_v  out  1  output valid.
- out_a  in  1  downstream acknowledge.
- busy  out  1  high while a message is locked (state LOCK).

Behaviour:
- Channel protocol: a transfer occurs in any cycle where v&a. The valid side holds d stable until acked. in_a is combinational, out_v is registered.
- Reset: state=IDLE, ptr=0, credit=0, out_v=0, out_d=0, out_src=0, busy=0, all in_a=0.
- Output register accepts a word when (!out_v | out_a). in_a[i] = (state==LOCK) & (grant==i) & (!out_v | out_a). A word is therefore in flight one cycle after acceptance, and full throughput (one word/clk) is sustained while out_a stays high.
- State IDLE:
  - If enable and any eligible source exists (in_v[i] & weights[i]!=0), choose the first eligible i scanning from ptr upward, mod Nsrc.
  - Set grant=i, credit=weights[i], go LOCK. The choice takes 1 cycle; no word is accepted in IDLE.
- State LOCK: on each accepted word, credit decrements.
  - If the word has in_last=1 and credit reaches 0 after decrement, or enable==0, or in_v[grant] will not follow: set ptr=grant+1 (mod Nsrc) and go IDLE.
  - If in_last=1 and credit>0 remains: stay LOCK on the same source for the next message, but only if in_v[grant] is high the next cycle. Otherwise release as above.
  - If in_last=0: stay LOCK regardless of credit. Messages are never split; credit saturates at 0 (no underflow) and overrun is tolerated.
- Weight sampling: weights are sampled only at grant time, so changes mid-turn take effect on the next grant.
- enable falling mid-message: the current message completes, then the block returns to IDLE and holds. Words already in the output register still drain.
- Round-robin wrap: ptr wraps from Nsrc-1 to 0.
- No eligible source: stay IDLE, ptr unchanged.
- Downstream stall (out_a=0 with out_v=1): in_a all 0, state and credit frozen.
- Simultaneous release and new request: the re-arbitration cycle is always spent in IDLE. One bubble per turn is accepted.
- busy = (state==LOCK).
- Asynchronous reset mid-message: abandon immediately. out_v drops in the same cycle reset asserts. Sources are expected to be reset by the same signal.

Decomposition:
- Shared package PCArbPkg holds: state enum {IDLE, LOCK}, default Nword (NPCcode+NPCdata+NPCroute), and the source index constants SRC_BD=0, SRC_FPGA=1, SRC_GLOBAL=2.
- One sub-module is natural: rr_pick, a combinational rotate-priority encoder taking (req vector, ptr) and returning (found, index). It is reusable for other shared resources.

Test Plan:
- Single source: weights={1,1,1}. Source 0 sends a 3-word message (last on word 3), out_a=1 -> out_d shows the 3 words on consecutive cycles with out_src=0, busy high for 3 cycles, then IDLE.
- Fairness: all sources continuously valid with 1-word messages, weights={2,1,1} -> output sequence by source 0,0,1,2,0,0,1,2…, with one IDLE bubble between turns.
- Atomicity: weight 1, source 1 sends a 4-word message -> all 4 words are granted contiguously (credit saturates at 0) before source 2 is served.
- Disable: weights[2]=0 with source 2 valid -> source 2 is never acked. enable=0 asserted after word 2 of a 3-word message -> word 3 still delivered, then no further in_a.
- Backpressure: out_a=0 for 5 cycles mid-message -> out_d held stable, in_a=0, no word lost or duplicated. out_a=1 resumes in order.
- Reset: assert reset=0 during LOCK with out_v=1 -> out_v, busy and in_a go 0 immediately. After release, the first grant goes to source 0 (ptr=0).
